// File: rtl/temp_display_if.sv
// Temperature display bus.
// Carries the converter results into the display driver and the driver's
// display/status outputs back out.
//   in_valid  1-cycle strobe qualifying temp_c/temp_f/unit_sel
//   temp_c    signed Celsius value
//   temp_f    signed Fahrenheit value
//   unit_sel  0 = Celsius, 1 = Fahrenheit
//   busy      conversion in progress (in_valid ignored)
//   seg       {g,f,e,d,c,b,a}, active-low
//   an        digit enables, active-low, an[0] = ones digit
//   dp        decimal point, active-low
// master: the producer side; slave: the display driver.
interface temp_display_if;
    logic               in_valid;
    logic signed [15:0] temp_c;
    logic signed [15:0] temp_f;
    logic               unit_sel;
    logic               busy;
    logic [6:0]         seg;
    logic [3:0]         an;
    logic               dp;

    modport master (
        output in_valid, temp_c, temp_f, unit_sel,
        input  busy, seg, an, dp
    );

    modport slave (
        input  in_valid, temp_c, temp_f, unit_sel,
        output busy, seg, an, dp
    );
endinterface

// File: rtl/temp_display_driver.sv
// temp_display_driver
// Captures a signed Celsius/Fahrenheit pair, picks one unit, saturates it,
// converts it to BCD with a sequential double-dabble FSM and scans the
// result onto a 4-digit active-low 7-segment display.
// Parameters:
//   REFRESH_DIV  clk cycles each digit stays lit before the scan advances (>=2)
// Ports:
//   clk    system clock, posedge
//   rst_n  synchronous active-low reset
//   bus    temp_display_if.slave (in_valid/temp_c/temp_f/unit_sel in,
//          busy/seg/an/dp out)
// Optional feature macro: TEMP_SIGN_EN -- negative values are shown with a
// minus glyph on the thousands digit and a magnitude clamped to 999. When
// undefined, negative values clamp to 0.
module temp_display_driver #(
    parameter int REFRESH_DIV = 100_000
) (
    input logic           clk,
    input logic           rst_n,
    temp_display_if.slave bus
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t      state, state_nxt;
    logic        load, shift, commit;
    logic [3:0]  count;
    logic [13:0] bin_sr;
    logic [15:0] bcd_sr;
    logic [29:0] dd_next;
    logic [15:0] disp_bcd;
`ifdef TEMP_SIGN_EN
    logic        neg_sr;
    logic        disp_neg;
`endif
    logic signed [15:0] sel_val;

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       scan_idx;
    logic [6:0]       seg_nxt;
    logic [3:0]       d0, d1, d2, d3;
    logic             blank1, blank2, blank3;
    logic [6:0]       seg_r;
    logic [3:0]       an_r;

    // Clamp to the displayable magnitude range.
    function automatic logic [13:0] sat_mag(input logic signed [15:0] v);
`ifdef TEMP_SIGN_EN
        logic signed [16:0] nv;
        // Negate in 17 bits so -32768 does not overflow.
        nv = -($signed({v[15], v}));
`endif
        if (v > 16'sd9999) begin
            return 14'd9999;
        end else if (v < 16'sd0) begin
`ifdef TEMP_SIGN_EN
            if (nv > 17'sd999) return 14'd999;
            else               return nv[13:0];
`else
            return 14'd0;
`endif
        end else begin
            return v[13:0];
        end
    endfunction

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Conversion FSM
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (count == 4'd13) state_nxt = COMMIT;
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);
    assign bus.dp   = 1'b1;
    assign sel_val  = bus.unit_sel ? bus.temp_f : bus.temp_c;
    assign dd_next  = {add3(bcd_sr), bin_sr} << 1;

    // Shift datapath: only meaningful between load and commit, so no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            bin_sr <= sat_mag(sel_val);
            bcd_sr <= 16'd0;
`ifdef TEMP_SIGN_EN
            neg_sr <= (sel_val < 16'sd0);
`endif
        end else if (shift) begin
            {bcd_sr, bin_sr} <= dd_next;
        end
    end

    // Count and displayed value; display only changes on commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= 4'd0;
            disp_bcd <= 16'd0;
`ifdef TEMP_SIGN_EN
            disp_neg <= 1'b0;
`endif
        end else begin
            if (load)       count <= 4'd0;
            else if (shift) count <= count + 4'd1;
            if (commit) begin
                disp_bcd <= bcd_sr;
`ifdef TEMP_SIGN_EN
                disp_neg <= neg_sr;
`endif
            end
        end
    end

    // Digit selection with leading-zero blanking
    assign d0     = disp_bcd[3:0];
    assign d1     = disp_bcd[7:4];
    assign d2     = disp_bcd[11:8];
    assign d3     = disp_bcd[15:12];
    assign blank3 = (d3 == 4'd0);
    assign blank2 = blank3 && (d2 == 4'd0);
    assign blank1 = blank2 && (d1 == 4'd0);

    always_comb begin
        seg_nxt = SEG_BLANK;
        case (scan_idx)
            2'd0: seg_nxt = glyph(d0);
            2'd1: seg_nxt = blank1 ? SEG_BLANK : glyph(d1);
            2'd2: seg_nxt = blank2 ? SEG_BLANK : glyph(d2);
            2'd3: begin
`ifdef TEMP_SIGN_EN
                if (disp_neg)    seg_nxt = SEG_MINUS;
                else if (blank3) seg_nxt = SEG_BLANK;
                else             seg_nxt = glyph(d3);
`else
                seg_nxt = blank3 ? SEG_BLANK : glyph(d3);
`endif
            end
            default: seg_nxt = SEG_BLANK;
        endcase
    end

    // Scan: refresh divider, digit index, registered an/seg (1-cycle lag)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
            seg_r       <= SEG_BLANK;
            an_r        <= 4'hF;
        end else begin
            if (refresh_cnt == CNT_MAX) begin
                refresh_cnt <= '0;
                scan_idx    <= scan_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            an_r  <= ~(4'b0001 << scan_idx);
            seg_r <= seg_nxt;
        end
    end

    assign bus.seg = seg_r;
    assign bus.an  = an_r;

endmodule

// File: tb/tb_temp_display_driver.sv
// Testbench for temp_display_driver (REFRESH_DIV = 4).
// Directed steps followed by randomized captures, each checked against a
// value-level model of the saturation and digit-rendering rules.
module tb_temp_display_driver;

    localparam int RDIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    temp_display_if bus ();

    temp_display_driver #(.REFRESH_DIV(RDIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [6:0] glyph_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};
    int pow10 [4] = '{1, 10, 100, 1000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_mag(input int v);
        if (v > 9999) return 9999;
        if (v < 0) begin
`ifdef TEMP_SIGN_EN
            return (-v > 999) ? 999 : -v;
`else
            return 0;
`endif
        end
        return v;
    endfunction

    function automatic bit model_neg(input int v);
`ifdef TEMP_SIGN_EN
        return v < 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [6:0] model_seg(input int val, input bit neg, input int idx);
        if (idx == 3 && neg)             return 7'b0111111;
        if (idx > 0 && val < pow10[idx]) return 7'b1111111;
        return glyph_tab[(val / pow10[idx]) % 10];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse in_valid for one edge; returns at the negedge after that edge.
    task automatic start(input int c, input int f, input bit sel);
        bus.temp_c   = 16'(c);
        bus.temp_f   = 16'(f);
        bus.unit_sel = sel;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts busy-high samples, bounded.
    task automatic busy_len(output int n);
        n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Watch a full scan period and check every digit shown.
    task automatic check_display(input string tag, input int val, input bit neg);
        logic [3:0] seen;
        int idx;
        seen = 4'h0;
        tick(1);
        for (int i = 0; i < 4 * RDIV + 2; i++) begin
            case (bus.an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            if (idx < 0) begin
                chk({tag, "_an_onehot"}, 32'(bus.an), 32'hE);
            end else begin
                seen[idx] = 1'b1;
                chk($sformatf("%s_seg%0d", tag, idx), 32'(bus.seg), 32'(model_seg(val, neg, idx)));
            end
            chk({tag, "_dp"}, 32'(bus.dp), 32'h1);
            tick(1);
        end
        chk({tag, "_all_digits"}, 32'(seen), 32'hF);
    endtask

    task automatic run_case(input string tag, input int c, input int f, input bit sel);
        int n, v;
        v = sel ? f : c;
        start(c, f, sel);
        busy_len(n);
        chk({tag, "_busy_len"}, 32'(n), 32'd15);
        check_display(tag, model_mag(v), model_neg(v));
    endtask

    initial begin
        int n, c, f, mode;
        bit sel;
        bus.in_valid = 1'b0;
        bus.temp_c   = '0;
        bus.temp_f   = '0;
        bus.unit_sel = 1'b0;

        // Reset values
        rst_n = 1'b0;
        tick(3);
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        chk("rst_an", 32'(bus.an), 32'hF);
        chk("rst_dp", 32'(bus.dp), 32'h1);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        tick(1);
        chk("rel_an", 32'(bus.an), 32'hE);
        chk("rel_seg", 32'(bus.seg), 32'h40);

        // Directed captures
        run_case("c25", 25, 0, 1'b0);
        run_case("f77", 0, 77, 1'b1);
        run_case("f12345", 0, 12345, 1'b1);
        run_case("c100", 100, 0, 1'b0);
        run_case("cneg50", -50, 0, 1'b0);
        run_case("cmin", -32768, 0, 1'b0);

        // Second pulse during busy is dropped
        start(25, 0, 1'b0);
        n = 0;
        while (bus.busy && n < 40) begin
            if (n == 4) begin
                bus.temp_c   = 16'(88);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        chk("drop_busy_len", 32'(n), 32'd15);
        check_display("drop", 25, 1'b0);

        // Pulse landing on the commit edge is dropped
        start(33, 0, 1'b0);
        n = 0;
        while (bus.busy && n < 40) begin
            if (n == 14) begin
                bus.temp_c   = 16'(44);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        chk("commit_busy_len", 32'(n), 32'd15);
        tick(1);
        chk("commit_drop_busy", 32'(bus.busy), 32'h0);
        check_display("commit_drop", 33, 1'b0);

        // Reset in the middle of a conversion
        start(88, 0, 1'b0);
        tick(6);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_an", 32'(bus.an), 32'hF);
        chk("midrst_seg", 32'(bus.seg), 32'h7F);
        rst_n = 1'b1;
        tick(20);
        chk("midrst_busy_after", 32'(bus.busy), 32'h0);
        check_display("midrst", 0, 1'b0);

        // Randomized captures
        for (int k = 0; k < 24; k++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       c = int'($urandom_range(0, 9999));
                1:       c = -int'($urandom_range(1, 2000));
                2:       c = int'($urandom_range(10000, 32767));
                default: c = int'($signed(16'($urandom)));
            endcase
            f   = int'($signed(16'($urandom)));
            sel = 1'($urandom);
            if (sel) begin
                n = f; f = c; c = n;
            end
            run_case($sformatf("rnd%0d", k), c, f, sel);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
